mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning address/data width.
REQ-002 SHALL have parameter BE_BITS, default 4, meaning byte-enable width (BITS/8).
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports are listed below.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- i_req  input  1  instruction-fetch request, held until granted
- i_addr  input  BITS  fetch address
- i_gnt  output  1  fetch request accepted this cycle
- i_rvalid  output  1  i_rdata valid
- i_rdata  output  BITS  fetch data
- d_req  input  1  data request, held until granted
- d_rw_  input  1  1 = read, 0 = write
- d_addr  input  BITS  data address
- d_wdata  input  BITS  write data
- d_byte_en  input  BE_BITS  byte enables
- d_lock  input  1  hold the port for D (LL/SC sequence)
- d_gnt  output  1  data request accepted this cycle
- d_ack  output  1  data access complete; d_rdata valid if read
- d_rdata  output  BITS  load data
- m_addr  output  BITS  shared memory address
- m_wdata  output  BITS  shared memory write data
- m_rw_  output  1  shared memory read/write, 1 = read
- m_byte_en  output  BE_BITS  shared memory byte enables
- m_rdata  input  BITS  shared memory read data, valid one cycle after the address

Function
REQ-004 SHALL grant at most one of i_gnt/d_gnt per cycle; the grant is combinational from the req inputs and the registered state.
REQ-005 SHALL drive m_* from the granted requester in the grant cycle; memory samples on that rising edge.
REQ-006 SHALL drive m_rw_=1, m_byte_en=0, m_addr=0, m_wdata=0 when no grant.
REQ-007 SHALL grant a lone requester immediately, giving zero-wait throughput of 1 access per cycle.
REQ-008 SHALL resolve simultaneous i_req and d_req round-robin: the requester not granted last wins; last_owner updates on every grant.
REQ-009 SHALL assert i_rvalid, or d_ack, exactly one cycle after the matching gnt (registered); d_ack fires for both reads and writes.
REQ-010 SHALL pass m_rdata to both i_rdata and d_rdata unmuxed; consumers qualify it with their valid/ack signal.
REQ-011 SHALL implement FSM states ARB and LOCK_D.
- ARB -> LOCK_D when d_gnt is issued with d_lock=1.
- LOCK_D: only D may be granted, and i_gnt=0.
- LOCK_D -> ARB on the first cycle d_lock is sampled 0; D may still be granted in that cycle.
REQ-012 SHALL grant D with no wait state while in LOCK_D, and SHALL still honour d_req=0 (no access).
REQ-013 SHALL never issue a gnt during the cycle rst=1.

Reset
REQ-014 SHALL, on rst=1 at a clock edge, set state=ARB, last_owner=I (so D wins the first conflict), i_rvalid=0, d_ack=0.
REQ-015 SHALL discard an in-flight response on reset mid-access: no rvalid/ack in the cycle after reset.

Structure
REQ-016 SHALL keep BITS and the arb_state_t enum (ARB, LOCK_D) in the shared cpu_params package/header.
REQ-017 SHALL contain one sub-module, arb_rr2: a 2-way round-robin picker (req[1:0], last_owner -> gnt[1:0]).

Verification
REQ-018 SHALL cover these scenarios:
- Lone I: i_req=1, i_addr=0x40, m_rdata=0xDEADBEEF next cycle -> i_gnt same cycle; i_rvalid=1 and i_rdata=0xDEADBEEF one cycle later.
- Conflict after reset: i_req=d_req=1 for 4 cycles -> grants D, I, D, I in turn; each followed one cycle later by d_ack or i_rvalid.
- Write: d_req=1, d_rw_=0, d_addr=0x100, d_wdata=0x12345678, d_byte_en=4'b0011 -> m_rw_=0 and m_byte_en=4'b0011 in the grant cycle; d_ack one cycle later.
- Lock: d_lock=1 on the first D grant, i_req held high for 3 cycles -> i_gnt=0 throughout; i_gnt=1 in the cycle after d_lock drops, if d_req=0.
- Reset mid-access: rst=1 in the cycle after d_gnt -> d_ack=0; state=ARB; the next conflict grants D.
- Idle: no requests -> m_rw_=1, m_byte_en=0, no gnt/valid/ack.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// Shared CPU-side parameters and arbiter types used by the memory arbiter slice.
package cpu_params;

  localparam int unsigned BITS    = 32;
  localparam int unsigned BE_BITS = BITS / 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCK_D = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin picker: bit 0 is instruction fetch, bit 1 is data.
module arb_rr2
  import cpu_params::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] gnt
);

  // On conflict the side that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last_owner == OWNER_I) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-cycle memory port between instruction fetch and data access,
// with round-robin on conflict and a lock that reserves the port for LL/SC.
module mem_arbiter #(
  parameter int unsigned BITS    = 32,
  parameter int unsigned BE_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [BITS-1:0]    i_addr,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [BITS-1:0]    i_rdata,
  input  logic               d_req,
  input  logic               d_rw_,
  input  logic [BITS-1:0]    d_addr,
  input  logic [BITS-1:0]    d_wdata,
  input  logic [BE_BITS-1:0] d_byte_en,
  input  logic               d_lock,
  output logic               d_gnt,
  output logic               d_ack,
  output logic [BITS-1:0]    d_rdata,
  output logic [BITS-1:0]    m_addr,
  output logic [BITS-1:0]    m_wdata,
  output logic               m_rw_,
  output logic [BE_BITS-1:0] m_byte_en,
  input  logic [BITS-1:0]    m_rdata
);

  import cpu_params::*;

  arb_state_t state;
  owner_t     last_owner;
  logic       i_rvalid_q;
  logic       d_ack_q;
  logic [1:0] rr_gnt;

  arb_rr2 u_rr (
    .req        ({d_req, i_req}),
    .last_owner (last_owner),
    .gnt        (rr_gnt)
  );

  // Grant selection; the lock shuts out fetch entirely.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (state == LOCK_D) begin
        d_gnt = d_req;
      end else begin
        i_gnt = rr_gnt[0];
        d_gnt = rr_gnt[1];
      end
    end
  end

  always_comb begin
    m_addr    = '0;
    m_wdata   = '0;
    m_rw_     = 1'b1;
    m_byte_en = '0;
    if (d_gnt) begin
      m_addr    = d_addr;
      m_wdata   = d_wdata;
      m_rw_     = d_rw_;
      m_byte_en = d_byte_en;
    end else if (i_gnt) begin
      m_addr    = i_addr;
      m_byte_en = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      last_owner <= OWNER_I;
      i_rvalid_q <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      i_rvalid_q <= i_gnt;
      d_ack_q    <= d_gnt;
      if (i_gnt) begin
        last_owner <= OWNER_I;
      end else if (d_gnt) begin
        last_owner <= OWNER_D;
      end
      case (state)
        ARB:     if (d_gnt && d_lock) state <= LOCK_D;
        LOCK_D:  if (!d_lock) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  // A response already in flight when reset arrives is dropped.
  assign i_rvalid = i_rvalid_q & ~rst;
  assign d_ack    = d_ack_q & ~rst;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_rw_;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_en;
  logic        d_lock;
  logic        d_gnt;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_rw_;
  logic [3:0]  m_byte_en;
  logic [31:0] m_rdata;

  mem_arbiter #(.BITS(32), .BE_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw_(d_rw_), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_lock(d_lock), .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rw_(m_rw_), .m_byte_en(m_byte_en), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the port, who won last, what responses are pending.
  bit locked      = 0;
  bit last_was_d  = 0;
  bit pend_i      = 0;
  bit pend_d      = 0;
  bit exp_i_gnt;
  bit exp_d_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic predict();
    exp_i_gnt = 0;
    exp_d_gnt = 0;
    if (!rst) begin
      if (locked) exp_d_gnt = d_req;
      else if (i_req && d_req) begin
        exp_d_gnt = !last_was_d;
        exp_i_gnt = last_was_d;
      end else begin
        exp_i_gnt = i_req;
        exp_d_gnt = d_req;
      end
    end
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle();
    #1;
    predict();
    check("i_gnt", 32'(i_gnt), 32'(exp_i_gnt));
    check("d_gnt", 32'(d_gnt), 32'(exp_d_gnt));
    check("i_rvalid", 32'(i_rvalid), 32'(pend_i && !rst));
    check("d_ack", 32'(d_ack), 32'(pend_d && !rst));
    check("i_rdata", i_rdata, m_rdata);
    check("d_rdata", d_rdata, m_rdata);
    if (exp_d_gnt) begin
      check("m_addr_d", m_addr, d_addr);
      check("m_wdata_d", m_wdata, d_wdata);
      check("m_rw_d", 32'(m_rw_), 32'(d_rw_));
      check("m_be_d", 32'(m_byte_en), 32'(d_byte_en));
    end else if (exp_i_gnt) begin
      check("m_addr_i", m_addr, i_addr);
      check("m_rw_i", 32'(m_rw_), 32'd1);
    end else begin
      check("m_addr_idle", m_addr, 32'd0);
      check("m_wdata_idle", m_wdata, 32'd0);
      check("m_rw_idle", 32'(m_rw_), 32'd1);
      check("m_be_idle", 32'(m_byte_en), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      locked = 0; last_was_d = 0; pend_i = 0; pend_d = 0;
    end else begin
      pend_i = exp_i_gnt;
      pend_d = exp_d_gnt;
      if (exp_i_gnt || exp_d_gnt) last_was_d = exp_d_gnt;
      if (!locked) locked = exp_d_gnt && d_lock;
      else         locked = d_lock;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; i_req = 0; i_addr = 0; d_req = 0; d_rw_ = 1; d_addr = 0;
    d_wdata = 0; d_byte_en = 0; d_lock = 0; m_rdata = $urandom;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    settle(); tick();
    settle(); tick();

    // Idle
    idle_inputs();
    settle();
    check("idle_rw", 32'(m_rw_), 32'd1);
    check("idle_gnt", 32'({i_gnt, d_gnt}), 32'd0);
    tick();

    // Lone fetch and its response
    i_req = 1; i_addr = 32'h40;
    settle();
    check("lone_i_gnt", 32'(i_gnt), 32'd1);
    check("lone_i_addr", m_addr, 32'h40);
    tick();
    i_req = 0; m_rdata = 32'hDEADBEEF;
    settle();
    check("lone_i_rvalid", 32'(i_rvalid), 32'd1);
    check("lone_i_rdata", i_rdata, 32'hDEADBEEF);
    tick();

    // Conflict right after reset: D, I, D, I
    rst = 1; settle(); tick();
    idle_inputs();
    i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      m_rdata = $urandom;
      settle();
      check("conflict_d", 32'(d_gnt), 32'((k % 2) == 0));
      check("conflict_i", 32'(i_gnt), 32'((k % 2) == 1));
      tick();
    end
    i_req = 0; d_req = 0;
    settle();
    check("conflict_last_rvalid", 32'(i_rvalid), 32'd1);
    tick();

    // Write
    d_req = 1; d_rw_ = 0; d_addr = 32'h100; d_wdata = 32'h12345678; d_byte_en = 4'b0011;
    settle();
    check("wr_rw", 32'(m_rw_), 32'd0);
    check("wr_be", 32'(m_byte_en), 32'h3);
    tick();
    idle_inputs();
    settle();
    check("wr_ack", 32'(d_ack), 32'd1);
    tick();

    // Lock holds fetch off until the cycle after d_lock drops
    rst = 1; settle(); tick();
    idle_inputs();
    i_req = 1; d_req = 1; d_lock = 1;
    settle();
    check("lock_first_d", 32'(d_gnt), 32'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      d_req = k[0];
      settle();
      check("lock_i_blocked", 32'(i_gnt), 32'd0);
      tick();
    end
    d_lock = 0; d_req = 0;
    settle();
    check("lock_drop_i_blocked", 32'(i_gnt), 32'd0);
    tick();
    settle();
    check("lock_release_i", 32'(i_gnt), 32'd1);
    tick();

    // Reset while a data access is in flight
    idle_inputs();
    d_req = 1;
    settle(); tick();
    idle_inputs();
    rst = 1;
    settle();
    check("rst_mid_ack", 32'(d_ack), 32'd0);
    tick();
    idle_inputs();
    settle();
    check("rst_after_ack", 32'(d_ack), 32'd0);
    tick();
    i_req = 1; d_req = 1;
    settle();
    check("rst_conflict_d", 32'(d_gnt), 32'd1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      i_req     = $urandom_range(0, 1);
      d_req     = $urandom_range(0, 1);
      d_lock    = ($urandom_range(0, 3) == 0);
      d_rw_     = $urandom_range(0, 1);
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_byte_en = 4'($urandom);
      m_rdata   = $urandom;
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
